// File: rtl/data_sync_arb_pkg.sv
// Shared FSM state type and width helpers for the data-synchronizer
// transmit arbiter and its request arbiter.
package data_sync_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_t;

   // Bits needed to encode the values 0..count-1, never less than one.
   function automatic int width_for(input int count);
      return (count <= 1) ? 1 : $clog2(count);
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/data_sync_rr_arbiter.sv
// Request arbiter for the shared synchronizer channel. Round-robin by default;
// `DATA_SYNC_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority.
module data_sync_rr_arbiter
   import data_sync_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = width_for(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               accept,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   logic [IDX_W-1:0] start_idx;
   int               scan_idx;
   logic             scan_hit;

`ifdef DATA_SYNC_ARB_FIXED_PRIO_EN
   logic unused_fixed_prio;

   assign unused_fixed_prio = ^{clk, rst, accept};
   assign start_idx         = '0;
`else
   logic [IDX_W-1:0] ptr;

   // The pointer moves just past the winner, and only when its word is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (accept) begin
         ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end else begin
         ptr <= ptr;
      end
   end

   assign start_idx = ptr;
`endif

   // Scan upward from start_idx with wrap-around; first active request wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      scan_hit  = 1'b0;
      scan_idx  = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         scan_idx = int'(start_idx) + off;
         if (scan_idx >= NUM_REQ) begin
            scan_idx = scan_idx - NUM_REQ;
         end else begin
            scan_idx = scan_idx;
         end
         if (!scan_hit && req[IDX_W'(scan_idx)]) begin
            grant[IDX_W'(scan_idx)] = 1'b1;
            grant_idx               = IDX_W'(scan_idx);
            scan_hit                = 1'b1;
         end else begin
            scan_hit = scan_hit;
         end
      end
   end

endmodule

// File: rtl/data_sync_tx_arbiter.sv
// Source-domain scheduler sharing one bus-synchronizer channel among NUM_REQ
// requesters. `DATA_SYNC_ARB_FIXED_PRIO_EN switches arbitration to fixed priority.
module data_sync_tx_arbiter
   import data_sync_arb_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int BUS_WIDTH   = 8,
   parameter  int HOLD_CYCLES = 4,
   parameter  int GAP_CYCLES  = 2,
   localparam int GID_W       = width_for(NUM_REQ),
   localparam int CNT_W       = width_for(max_of(HOLD_CYCLES, GAP_CYCLES) + 1)
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [BUS_WIDTH-1:0]         unsync_bus,
   output logic                         bus_enable,
   output logic [GID_W-1:0]             grant_id,
   output logic                         busy
);

   arb_state_t           state;
   arb_state_t           next_state;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     next_cnt;
   logic                 idle;
   logic                 accept;
   logic [NUM_REQ-1:0]   live_req;
   logic [NUM_REQ-1:0]   grant;
   logic [GID_W-1:0]     grant_idx;
   logic [BUS_WIDTH-1:0] win_data;

   // Requests only count in IDLE and never while reset is held.
   assign idle      = (state == ST_IDLE) && !RST;
   assign live_req  = idle ? req_valid : '0;
   assign accept    = |live_req;
   assign req_ready = grant;
   assign busy      = (state != ST_IDLE);

   data_sync_rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_arb (
      .clk      (CLK),
      .rst      (RST),
      .req      (live_req),
      .accept   (accept),
      .grant    (grant),
      .grant_idx(grant_idx)
   );

   // One-hot grant steers the winning word onto the capture path.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         win_data = win_data | ({BUS_WIDTH{grant[i]}} & req_data[i*BUS_WIDTH +: BUS_WIDTH]);
      end
   end

   // Next-state and hold/gap counter.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               next_state = ST_HOLD;
               next_cnt   = CNT_W'(HOLD_CYCLES - 1);
            end else begin
               next_state = ST_IDLE;
               next_cnt   = cnt;
            end
         end
         ST_HOLD: begin
            if (cnt == '0) begin
               next_state = ST_GAP;
               next_cnt   = CNT_W'(GAP_CYCLES - 1);
            end else begin
               next_state = ST_HOLD;
               next_cnt   = cnt - CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt == '0) begin
               next_state = ST_IDLE;
               next_cnt   = '0;
            end else begin
               next_state = ST_GAP;
               next_cnt   = cnt - CNT_W'(1);
            end
         end
         default: begin
            next_state = ST_IDLE;
            next_cnt   = '0;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // Word and id change only on acceptance; enable mirrors the HOLD window.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         unsync_bus <= '0;
         grant_id   <= '0;
         bus_enable <= 1'b0;
      end else begin
         bus_enable <= (next_state == ST_HOLD);
         if (accept) begin
            unsync_bus <= win_data;
            grant_id   <= grant_idx;
         end else begin
            unsync_bus <= unsync_bus;
            grant_id   <= grant_id;
         end
      end
   end

endmodule

// File: tb/tb_data_sync_tx_arbiter.sv
// Self-checking bench for data_sync_tx_arbiter: requester models, a timing
// model of the enable/busy windows and a scoreboard of expected acceptances.
module tb_data_sync_tx_arbiter;

   localparam int NR    = 4;
   localparam int BW    = 8;
   localparam int HOLD  = 4;
   localparam int GAP   = 2;
   localparam int GW    = 2;
   localparam int NEVER = 32'h7fff_ffff;

   logic             CLK;
   logic             RST;
   logic [NR-1:0]    req_valid;
   logic [NR*BW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic [BW-1:0]    unsync_bus;
   logic             bus_enable;
   logic [GW-1:0]    grant_id;
   logic             busy;

   typedef struct {
      int            idx;
      logic [BW-1:0] data;
      int            gap;
   } exp_t;

   exp_t          sb[$];
   int            n_checks = 0;
   int            n_pass   = 0;
   int            cyc      = 0;
   int            req_count[NR];
   int            granted_cnt[NR];
   int            start_cyc[NR];
   int            stop_cyc[NR];
   logic [BW-1:0] req_word[NR];
   logic          holdoff[NR];
   logic          acc_valid = 1'b0;
   int            acc_cyc   = 0;
   logic [BW-1:0] exp_bus   = '0;
   logic [GW-1:0] exp_gid   = '0;

   data_sync_tx_arbiter #(
      .NUM_REQ    (NR),
      .BUS_WIDTH  (BW),
      .HOLD_CYCLES(HOLD),
      .GAP_CYCLES (GAP)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .unsync_bus(unsync_bus),
      .bus_enable(bus_enable),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
      end
   endtask

   task automatic push_exp(input int idx, input logic [BW-1:0] d, input int gap);
      exp_t e;
      e.idx  = idx;
      e.data = d;
      e.gap  = gap;
      sb.push_back(e);
   endtask

   task automatic add_req(input int i, input logic [BW-1:0] d, input int n, input int start, input int stop);
      req_word[i]  = d;
      req_count[i] = granted_cnt[i] + n;
      start_cyc[i] = start;
      stop_cyc[i]  = stop;
   endtask

   // Requesters hold valid until granted and drop it for the cycle after.
   task automatic drive_reqs();
      for (int i = 0; i < NR; i++) begin
         req_valid[i] = (granted_cnt[i] < req_count[i]) && !holdoff[i] &&
                        (cyc >= start_cyc[i]) && (cyc < stop_cyc[i]);
         holdoff[i] = 1'b0;
         req_data[i*BW +: BW] = req_word[i];
      end
   endtask

   task automatic monitor();
      int   since;
      logic exp_en;
      logic exp_busy;
      exp_t it;
      if (RST) begin
         acc_valid = 1'b0;
         exp_bus   = '0;
         exp_gid   = '0;
         return;
      end
      since    = acc_valid ? (cyc - acc_cyc) : 1000;
      exp_en   = acc_valid && (since >= 1) && (since <= HOLD);
      exp_busy = acc_valid && (since >= 1) && (since <= HOLD + GAP);
      check_eq("bus_enable", 32'(bus_enable), 32'(exp_en));
      check_eq("busy", 32'(busy), 32'(exp_busy));
      check_eq("unsync_bus", 32'(unsync_bus), 32'(exp_bus));
      check_eq("grant_id", 32'(grant_id), 32'(exp_gid));
      if (exp_busy || (req_valid == '0)) begin
         check_eq("ready_quiet", 32'(req_ready), 32'd0);
      end else if (sb.size() == 0) begin
         check_eq("ready_unplanned", 32'(req_ready), 32'd0);
      end else begin
         it = sb.pop_front();
         check_eq("winner", 32'(req_ready), 32'd1 << it.idx);
         if (acc_valid && (it.gap != 0)) begin
            check_eq("spacing", 32'(since), 32'(it.gap));
         end
         acc_valid = 1'b1;
         acc_cyc   = cyc;
         exp_bus   = it.data;
         exp_gid   = GW'(it.idx);
         granted_cnt[it.idx]++;
         holdoff[it.idx] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      cyc++;
      #1 drive_reqs();
      #5 monitor();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
      end
   endtask

   task automatic apply_reset();
      RST = 1'b1;
      for (int i = 0; i < NR; i++) begin
         req_count[i] = granted_cnt[i];
         holdoff[i]   = 1'b0;
         start_cyc[i] = 0;
         stop_cyc[i]  = NEVER;
      end
      #1;
      check_eq("rst_bus_enable", 32'(bus_enable), 32'd0);
      check_eq("rst_unsync_bus", 32'(unsync_bus), 32'd0);
      check_eq("rst_grant_id", 32'(grant_id), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_ready", 32'(req_ready), 32'd0);
      run(2);
      RST = 1'b0;
   endtask

   initial begin
      RST       = 1'b0;
      req_valid = '0;
      req_data  = '0;
      for (int i = 0; i < NR; i++) begin
         req_count[i]   = 0;
         granted_cnt[i] = 0;
         start_cyc[i]   = 0;
         stop_cyc[i]    = NEVER;
         req_word[i]    = '0;
         holdoff[i]     = 1'b0;
      end
      #2;

      // Single request from requester 0.
      apply_reset();
      add_req(0, 8'hA5, 1, cyc + 1, NEVER);
      push_exp(0, 8'hA5, 0);
      run(12);
      check_eq("sb_drain_single", 32'(sb.size()), 32'd0);

      // All four requesting; requester 0 keeps coming back.
      apply_reset();
      add_req(0, 8'h10, 3, cyc + 1, NEVER);
      add_req(1, 8'h11, 1, cyc + 1, NEVER);
      add_req(2, 8'h12, 1, cyc + 1, NEVER);
      add_req(3, 8'h13, 1, cyc + 1, NEVER);
`ifdef DATA_SYNC_ARB_FIXED_PRIO_EN
      push_exp(0, 8'h10, 0);
      push_exp(0, 8'h10, 7);
      push_exp(0, 8'h10, 7);
      push_exp(1, 8'h11, 7);
      push_exp(2, 8'h12, 7);
      push_exp(3, 8'h13, 7);
`else
      push_exp(0, 8'h10, 0);
      push_exp(1, 8'h11, 7);
      push_exp(2, 8'h12, 7);
      push_exp(3, 8'h13, 7);
      push_exp(0, 8'h10, 7);
      push_exp(0, 8'h10, 7);
`endif
      run(50);
      check_eq("sb_drain_all4", 32'(sb.size()), 32'd0);

      // Requester 2 arrives during HOLD and must wait for IDLE.
      apply_reset();
      add_req(1, 8'h21, 1, cyc + 1, NEVER);
      add_req(2, 8'h32, 1, cyc + 3, NEVER);
      push_exp(1, 8'h21, 0);
      push_exp(2, 8'h32, 7);
      run(20);
      check_eq("sb_drain_late", 32'(sb.size()), 32'd0);

      // Requester 3 withdraws in the last GAP cycle: never accepted.
      apply_reset();
      add_req(0, 8'h01, 1, cyc + 1, NEVER);
      add_req(3, 8'h3C, 1, cyc + 3, cyc + 7);
      push_exp(0, 8'h01, 0);
      run(16);
      check_eq("sb_drain_withdraw", 32'(sb.size()), 32'd0);
      check_eq("withdraw_not_taken", 32'(granted_cnt[3]), 32'(req_count[3] - 1));

      // Reset in the second HOLD cycle, then requester 1 is served first.
      apply_reset();
      add_req(0, 8'h5A, 1, cyc + 1, NEVER);
      push_exp(0, 8'h5A, 0);
      run(3);
      RST = 1'b1;
      #1;
      check_eq("midrst_bus_enable", 32'(bus_enable), 32'd0);
      check_eq("midrst_unsync_bus", 32'(unsync_bus), 32'd0);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      check_eq("midrst_grant_id", 32'(grant_id), 32'd0);
      add_req(1, 8'h77, 1, cyc + 1, NEVER);
      push_exp(1, 8'h77, 0);
      for (int k = 0; k < 2; k++) begin
         tick();
         check_eq("ready_in_rst", 32'(req_ready), 32'd0);
      end
      RST = 1'b0;
      #1;
      check_eq("ready_after_rst", 32'(req_ready), 32'h2);
      #1 monitor();
      run(10);
      check_eq("sb_drain_midrst", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/data_sync_tx_arbiter.md
# data_sync_tx_arbiter

Source-domain scheduler that shares one data-synchronizer channel (`unsync_bus` / `bus_enable`) among `NUM_REQ` requesters. It accepts one word at a time by valid/ready handshake, registers it, and holds it stable with `bus_enable` high for `HOLD_CYCLES`. It then drops `bus_enable` for `GAP_CYCLES`, which guarantees a clean rising edge for the destination-side enable synchronizer and pulse generator. It sits in the transmitting clock domain, directly in front of the bus synchronizer.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥1.
- `BUS_WIDTH`, 8: data word width.
- `HOLD_CYCLES`, 4: cycles `bus_enable` stays high per transfer; must be ≥1. Sized so the destination captures after `NUM_STAGES` plus pulse generation.
- `GAP_CYCLES`, 2: cycles `bus_enable` stays low between transfers; must be ≥1.
- `CLK`, input, 1: source-domain clock; all logic is rising-edge.
- `RST`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, `NUM_REQ`: per-requester request.
- `req_data`, input, `NUM_REQ*BUS_WIDTH`: requester i occupies bits `[i*BUS_WIDTH +: BUS_WIDTH]`.
- `req_ready`, output, `NUM_REQ`: one-hot, one-cycle acceptance strobe.
- `unsync_bus`, output, `BUS_WIDTH`: registered data to the synchronizer.
- `bus_enable`, output, 1: registered enable to the synchronizer.
- `grant_id`, output, `$clog2(NUM_REQ)` (min 1): index of the requester in service; registered.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, HOLD, GAP.
- **IDLE**
  - If any `req_valid` is high, the arbiter picks a winner and asserts `req_ready[winner]` combinationally in that cycle.
  - At the clock edge it registers `req_data[winner]` into `unsync_bus` and the winner into `grant_id`, loads the counter with `HOLD_CYCLES-1`, and moves to HOLD.
- **HOLD**
  - `bus_enable` is 1.
  - The counter decrements each cycle. When it reaches 0, load `GAP_CYCLES-1` and move to GAP.
- **GAP**
  - `bus_enable` is 0.
  - The counter decrements each cycle. When it reaches 0, move to IDLE.
- `unsync_bus` and `grant_id` hold their values through HOLD and GAP, and keep them until the next acceptance.
- `req_valid` is ignored outside IDLE, and `req_ready` is 0 outside IDLE.
- Requester rules:
  - A requester holds `req_valid` and its data until it sees `req_ready`.
  - It must drop `req_valid` in the cycle after `req_ready`; otherwise the arbiter treats it as a new request.
  - Withdrawing `req_valid` before acceptance is legal and has no effect.
- Arbitration (default) is round-robin.
  - Search starts at `(last_grant+1) mod NUM_REQ`.
  - The pointer updates only on acceptance.
  - After reset, requester 0 has highest priority.
- Reset values: state IDLE, `bus_enable` 0, `unsync_bus` 0, `grant_id` 0, `req_ready` 0, `busy` 0, counter 0, round-robin pointer set so index 0 is searched first.
- Reset mid-transfer: the in-flight word is abandoned and `bus_enable` falls immediately (asynchronous). Requests that were not yet accepted are retained by their requesters.

## Timing
- If acceptance happens in cycle N:
  - `bus_enable` is high in cycles N+1 through N+HOLD_CYCLES.
  - `bus_enable` is low in cycles N+HOLD_CYCLES+1 through N+HOLD_CYCLES+GAP_CYCLES.
  - The next acceptance can occur in cycle N+HOLD_CYCLES+GAP_CYCLES+1 at the earliest.
- Peak throughput: one word per `HOLD_CYCLES+GAP_CYCLES+1` cycles.
- `unsync_bus` changes only on the acceptance edge, so it is never updated while `bus_enable` is high.
- Counter width is `$clog2(max(HOLD_CYCLES,GAP_CYCLES)+1)`.

## Configuration
- `DATA_SYNC_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority; the lowest-index valid requester always wins and no pointer register exists.
  - Undefined: round-robin as described in Operation.

## Structure
- Package `data_sync_arb_pkg` holds:
  - the FSM state typedef (IDLE, HOLD, GAP);
  - a width-helper function for the counter and `grant_id` widths.
- Sub-module `data_sync_rr_arbiter`:
  - parameterised on `NUM_REQ`;
  - inputs: request vector, accept strobe;
  - outputs: one-hot grant and encoded index;
  - owns the pointer and the fixed-priority macro variant.

## Test plan
- Reset then single request: `req_valid`=0001, data0=8'hA5 → `req_ready`=0001 in the same cycle; `unsync_bus`=A5 and `bus_enable`=1 for exactly 4 cycles; then 0 for 2 cycles; `busy` falls after 6 cycles.
- All four requesting continuously, data i = 8'h10+i → grant order 0,1,2,3,0 with acceptances spaced 7 cycles apart (round-robin build).
- Same stimulus with `DATA_SYNC_ARB_FIXED_PRIO_EN` defined, and requester 0 re-asserting valid after each grant → requester 0 always wins; requesters 1 to 3 starve.
- Requester 2 raises `req_valid` during HOLD → no `req_ready` until IDLE; accepted in cycle N+7; `unsync_bus` stays stable while `bus_enable`=1.
- `RST` asserted in the second HOLD cycle → `bus_enable`=0, `unsync_bus`=0, `busy`=0 immediately; after release with requester 1 valid, `req_ready`=0010 in the first active cycle.
- Requester 3 withdraws `req_valid` the cycle before IDLE → no acceptance; outputs stay idle.
